keypad_entry_ctrl: RTL
======================

Name: keypad_entry_ctrl

Overview:
- Sequences the keypad scanner output into a 4-digit numeric entry.
- Debounces the raw key/pressed pair and issues exactly one event per physical press.
- Interprets each event as digit, clear, backspace or enter, and maintains a 4-digit BCD entry buffer with a blank mask for the FTSD path.
- Sits between keypad_scan and the FTSD_decoder/FTSD_scan chain and runs on the same scan clock as keypad_scan.

Parameters:
- DB_CYCLES, 4: consecutive stable samples required to accept a press or a release (range 1..15).
- KEY_CLR, 4'hA: key code for clear.
- KEY_BSP, 4'hB: key code for backspace.
- KEY_ENT, 4'hE: key code for enter.

Ports:
- clk  in  1  scan-domain clock; all logic rising-edge.
- rst  in  1  synchronous reset, active-high.
- key  in  4  key code from scanner; valid only while pressed=1.
- pressed  in  1  raw key-down indication from scanner.
- digits  out  16  BCD entry buffer; [15:12] most significant, [3:0] newest digit.
- blank  out  4  bit i=1 means digit i is unused and must be blanked on display.
- digit_cnt  out  3  number of digits entered, 0..4.
- result  out  16  BCD value latched on enter.
- result_valid  out  1  one-cycle pulse when result updates.
- key_event  out  1  one-cycle pulse per accepted press.
- key_code  out  4  code of the last accepted press.
- overflow  out  1  sticky; set when a digit is rejected because the buffer is full.

Behaviour:
- Reset (rst=1 at a clock edge): all outputs 0 except blank=4'b1111; FSM goes to IDLE; debounce counter=0. Reset overrides everything in the same cycle, including reset mid-debounce or mid-hold.
- FSM states: IDLE, DB_PRESS, HELD, DB_REL.
  - IDLE: pressed=1 -> DB_PRESS; capture key into cand; cnt=1.
  - DB_PRESS, pressed=1 and key==cand: cnt++.
    - When cnt reaches DB_CYCLES -> HELD, and the accept action fires in that same cycle.
  - DB_PRESS, pressed=0 or key!=cand: return to IDLE, cnt=0. No event.
  - HELD: pressed=0 -> DB_REL, cnt=1. A key change while pressed=1 stays in HELD with no event (no auto-repeat, no rollover).
  - DB_REL, pressed=0: cnt++; at DB_CYCLES -> IDLE.
  - DB_REL, pressed=1: return to HELD, cnt=0 (bounce on release).
- Accept action (single cycle): key_event=1; key_code=cand.
  - Digit (cand<=9), digit_cnt<4: digits <= {digits[11:0],cand}; digit_cnt++; blank <= {blank[2:0],1'b0}.
  - Digit, digit_cnt==4: buffer unchanged; overflow<=1.
  - KEY_CLR: digits=0, digit_cnt=0, blank=4'b1111, overflow=0.
  - KEY_BSP, digit_cnt>0: digits <= {4'h0,digits[15:4]}; digit_cnt--; blank <= {1'b1,blank[3:1]}.
  - KEY_BSP, digit_cnt==0: no change.
  - KEY_ENT: result<=digits; result_valid=1; then clear the buffer exactly as KEY_CLR does. Enter with digit_cnt==0 still pulses result_valid with result=0.
  - Any other code (A..F not assigned): key_event/key_code update only.
- Registered outputs, updated on the accepting edge.
  - Latency: last of DB_CYCLES stable samples -> key_event high that same edge.
  - Minimum from the first pressed=1 sample to key_event: DB_CYCLES cycles.
- key_event and result_valid are high for exactly one cycle and never assert outside the accept cycle.
- Invariant: blank == ~((4'b1 << digit_cnt) - 1) [3:0] at all times.
- digit_cnt never exceeds 4 or goes below 0; there is no wrap-around.

Test Plan:
- Reset with rst=1 for 2 cycles -> digits=0, blank=4'b1111, digit_cnt=0, all pulses 0.
- Press 1,2,3 cleanly (each held 8 cycles, release 8 cycles), DB_CYCLES=4 -> 3 key_event pulses; digits=16'h0123, blank=4'b1000, digit_cnt=3.
- Bounce: pressed toggles 1,0,1,1,0 with key=5, then holds 1 for 4 cycles -> exactly one key_event, 4th stable cycle; digits low nibble=5. Release bounce 0,1,0,0,0,0 -> no second event.
- Enter 9,8,7,6,5 then B, then E -> 5th digit sets overflow with digits=16'h9876. Backspace gives 16'h0987 with digit_cnt=3. Enter gives result=16'h0987, result_valid one cycle, digits=0, blank=4'b1111.
- Press C (unassigned) and B on empty buffer -> key_event pulses with key_code=C then B; digits, digit_cnt and blank unchanged.
- Assert rst while in HELD with digit_cnt=2, then release the key after rst deasserts -> all outputs at reset values and no key_event on release.

Source files
------------

// File: rtl/keypad_entry_ctrl.sv
// Debounces the keypad scanner's key/pressed pair into one event per press and
// builds a 4-digit BCD entry (with blank mask) plus a result latched on enter.
module keypad_entry_ctrl #(
  parameter int          DB_CYCLES = 4,
  parameter logic [3:0]  KEY_CLR   = 4'hA,
  parameter logic [3:0]  KEY_BSP   = 4'hB,
  parameter logic [3:0]  KEY_ENT   = 4'hE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key,
  input  logic        pressed,
  output logic [15:0] digits,
  output logic [3:0]  blank,
  output logic [2:0]  digit_cnt,
  output logic [15:0] result,
  output logic        result_valid,
  output logic        key_event,
  output logic [3:0]  key_code,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_REL} state_t;

  localparam logic [3:0] DB_LAST = 4'(DB_CYCLES);
  localparam bit         DB_ONE  = (DB_CYCLES == 1);

  state_t     state;
  logic [3:0] cnt;
  logic [3:0] cand;
  logic       accept;
  logic [3:0] acc_code;

  // With a single-sample debounce the press is accepted straight out of IDLE.
  always_comb begin
    accept   = 1'b0;
    acc_code = cand;
    if (state == IDLE) begin
      acc_code = key;
      accept   = pressed && DB_ONE;
    end else if (state == DB_PRESS) begin
      accept   = pressed && (key == cand) && ((cnt + 4'd1) == DB_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      cand         <= 4'd0;
      digits       <= 16'h0000;
      blank        <= 4'b1111;
      digit_cnt    <= 3'd0;
      result       <= 16'h0000;
      result_valid <= 1'b0;
      key_event    <= 1'b0;
      key_code     <= 4'd0;
      overflow     <= 1'b0;
    end else begin
      key_event    <= 1'b0;
      result_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (pressed) begin
            cand <= key;
            if (DB_ONE) begin
              state <= HELD;
              cnt   <= 4'd0;
            end else begin
              state <= DB_PRESS;
              cnt   <= 4'd1;
            end
          end
        end
        DB_PRESS: begin
          if (pressed && (key == cand)) begin
            if ((cnt + 4'd1) == DB_LAST) begin
              state <= HELD;
              cnt   <= 4'd0;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end else begin
            state <= IDLE;
            cnt   <= 4'd0;
          end
        end
        // Key changes while held are ignored: no auto-repeat, no rollover.
        HELD: begin
          if (!pressed) begin
            if (DB_ONE) begin
              state <= IDLE;
              cnt   <= 4'd0;
            end else begin
              state <= DB_REL;
              cnt   <= 4'd1;
            end
          end
        end
        DB_REL: begin
          if (pressed) begin
            state <= HELD;
            cnt   <= 4'd0;
          end else if ((cnt + 4'd1) == DB_LAST) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase

      if (accept) begin
        key_event <= 1'b1;
        key_code  <= acc_code;
        if (acc_code <= 4'd9) begin
          if (digit_cnt != 3'd4) begin
            digits    <= {digits[11:0], acc_code};
            digit_cnt <= digit_cnt + 3'd1;
            blank     <= {blank[2:0], 1'b0};
          end else begin
            overflow <= 1'b1;
          end
        end else if (acc_code == KEY_CLR) begin
          digits    <= 16'h0000;
          digit_cnt <= 3'd0;
          blank     <= 4'b1111;
          overflow  <= 1'b0;
        end else if (acc_code == KEY_BSP) begin
          if (digit_cnt != 3'd0) begin
            digits    <= {4'h0, digits[15:4]};
            digit_cnt <= digit_cnt - 3'd1;
            blank     <= {1'b1, blank[3:1]};
          end
        end else if (acc_code == KEY_ENT) begin
          result       <= digits;
          result_valid <= 1'b1;
          digits       <= 16'h0000;
          digit_cnt    <= 3'd0;
          blank        <= 4'b1111;
          overflow     <= 1'b0;
        end
      end
    end
  end

endmodule
